// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_t;

  // Chunk-index register width; never narrower than one bit.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into the top bit.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < CHUNK; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[CHUNK];
  assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit add/subtract computed CHUNK bits per clock through a registered carry,
// with valid/ready handshakes on both sides.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  adder_state_t   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout, chunk_cmsb;

  assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i    (chunk_a),
    .b_i    (chunk_b),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout),
    .cmsb_o (chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          // Subtract is A + ~B + 1, so cin_i is overridden.
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_cout;
          ovf_d   = chunk_cmsb ^ chunk_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_o     = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder: an 8-bit/2-bit-chunk instance and a 1-bit half-adder instance.
module tb_multicycle_adder;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, out_ready, cin, sub;
  logic [7:0] a, b;
  logic       in_ready, out_valid, carry, ovf;
  logic [7:0] sum;

  logic       h_in_valid, h_out_ready, h_cin, h_sub;
  logic [0:0] h_a, h_b, h_sum;
  logic       h_in_ready, h_out_valid, h_carry, h_ovf;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .carry_o(carry), .ovf_o(ovf)
  );

  multicycle_adder #(.WIDTH(1), .CHUNK(1)) dut_half (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(h_in_valid), .in_ready_o(h_in_ready),
    .a_i(h_a), .b_i(h_b), .cin_i(h_cin), .sub_i(h_sub),
    .out_valid_o(h_out_valid), .out_ready_i(h_out_ready),
    .sum_o(h_sum), .carry_o(h_carry), .ovf_o(h_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: word-level add of A and B' with sign-rule overflow.
  function automatic exp_t model(input int w, input logic [7:0] ai, input logic [7:0] bi,
                                 input logic ci, input logic si);
    exp_t e;
    logic [8:0] full;
    logic [7:0] mask, bp, s;
    mask = 8'((9'h1 << w) - 9'h1);
    bp   = (si ? ~bi : bi) & mask;
    full = {1'b0, ai & mask} + {1'b0, bp} + {8'h0, (si ? 1'b1 : ci)};
    s    = full[7:0] & mask;
    e.sum   = s;
    e.carry = full[w];
    e.ovf   = (ai[w-1] == bp[w-1]) && (s[w-1] != ai[w-1]);
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic si, input int hold);
    exp_t e;
    int   cyc;
    @(negedge clk);
    in_valid = 1'b1; a = ai; b = bi; cin = ci; sub = si;
    sb.push_back(model(8, ai, bi, ci, si));
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ai; b = ~bi; cin = ~ci; sub = ~si;
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!out_valid) chk({tag, "_in_ready_wait"}, in_ready, 0);
    end
    chk({tag, "_latency"}, cyc, 4);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_ready"}, in_ready, 0);
      chk({tag, "_hold_sum"}, sum, sb[0].sum);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = sb.pop_front();
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_carry"}, carry, e.carry);
    chk({tag, "_ovf"}, ovf, e.ovf);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic run_half(input logic ai, input logic bi);
    exp_t e;
    @(negedge clk);
    h_in_valid = 1'b1; h_a = ai; h_b = bi; h_cin = 1'b0; h_sub = 1'b0;
    sb.push_back(model(1, {7'h0, ai}, {7'h0, bi}, 1'b0, 1'b0));
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    chk("half_not_ready", h_in_ready, 0);
    @(posedge clk); #1;
    chk("half_latency1", h_out_valid, 1);
    e = sb.pop_front();
    chk("half_sum", h_sum, e.sum[0]);
    chk("half_carry", h_carry, e.carry);
    chk("half_ovf", h_ovf, e.ovf);
    h_out_ready = 1'b1;
    @(posedge clk); #1;
    h_out_ready = 1'b0;
    chk("half_back_idle", h_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    h_in_valid = 1'b0; h_out_ready = 1'b0; h_a = '0; h_b = '0; h_cin = 1'b0; h_sub = 1'b0;
    #12;
    in_valid = 1'b1;
    #10;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op("80_plus_80", 8'h80, 8'h80, 1'b0, 1'b0, 0);
    run_op("05_minus_07", 8'h05, 8'h07, 1'b1, 1'b1, 0);
    run_op("07_minus_05", 8'h07, 8'h05, 1'b0, 1'b1, 0);
    run_op("cin_add", 8'h3C, 8'h41, 1'b1, 1'b0, 0);
    run_op("backpressure", 8'hA5, 8'h5A, 1'b1, 1'b0, 3);

    // Abort an operation two cycles after accept.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 8'h10, 8'h20, 1'b0, 1'b0, 0);

    for (int i = 0; i < 4; i++) run_half(i[1], i[0]);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
